// File: rtl/cnt_seq_pkg.sv
// ----------------------------------------------------------------------------
// cnt_seq_pkg
// Shared types for the counter command sequencer: the command opcode, the
// sequencer FSM state, the packed command word held in the FIFO, and the
// default widths/depth used by the sequencer and its FIFO.
// ----------------------------------------------------------------------------
package cnt_seq_pkg;

   localparam int DEF_DATA_W     = 16;
   localparam int DEF_LEN_W      = 8;
   localparam int DEF_FIFO_DEPTH = 4;

   typedef enum logic [1:0] {
      LOAD = 2'd0,
      UP   = 2'd1,
      DOWN = 2'd2,
      HOLD = 2'd3
   } op_t;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      EXEC = 1'b1
   } state_t;

   typedef struct packed {
      op_t                   op;
      logic [DEF_DATA_W-1:0] arg;
   } cmd_t;

   // True for the opcodes that make the counter count (before the N=0 check).
   function automatic logic is_count_op(input op_t op);
      return (op == UP) || (op == DOWN);
   endfunction

endpackage

// File: rtl/cnt_cmd_fifo.sv
// ----------------------------------------------------------------------------
// cnt_cmd_fifo
// Synchronous FIFO of cmd_t words with a combinational head read.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   push, wr_data write a command (ignored while full or flushing)
//   pop, rd_data  remove the head command; rd_data always shows the head
//   flush         synchronous empty; wins over push and pop
//   full, empty   occupancy flags
//   count         number of held entries (0..DEPTH)
// ----------------------------------------------------------------------------
module cnt_cmd_fifo
   import cnt_seq_pkg::*;
#(
   parameter int DEPTH = DEF_FIFO_DEPTH
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     flush,
   input  cmd_t                     wr_data,
   output cmd_t                     rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [AW-1:0] PTR_ONE = AW'(1'b1);
   localparam logic [CW-1:0] CNT_ONE = CW'(1'b1);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

   cmd_t          mem_r [DEPTH];
   logic [AW-1:0] wr_ptr_r;
   logic [AW-1:0] rd_ptr_r;
   logic [CW-1:0] count_r;
   logic          do_push_s;
   logic          do_pop_s;

   assign full    = (count_r == CNT_MAX);
   assign empty   = (count_r == {CW{1'b0}});
   assign count   = count_r;
   assign rd_data = mem_r[rd_ptr_r];

   // Qualify requests: a flush cancels both, and full/empty block overrun.
   always_comb begin
      do_push_s = push && !full && !flush;
      do_pop_s  = pop && !empty && !flush;
   end

   // Storage write; contents need no reset since count gates every read.
   always_ff @(posedge clk) begin
      if (do_push_s) begin
         mem_r[wr_ptr_r] <= wr_data;
      end
   end

   // Pointers and occupancy; DEPTH is a power of two so pointers wrap freely.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         count_r  <= {CW{1'b0}};
      end else if (flush) begin
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         count_r  <= {CW{1'b0}};
      end else begin
         if (do_push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
         end
         if (do_pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
         case ({do_push_s, do_pop_s})
            2'b10:   count_r <= count_r + CNT_ONE;
            2'b01:   count_r <= count_r - CNT_ONE;
            default: count_r <= count_r;
         endcase
      end
   end

endmodule

// File: rtl/cnt_cmd_seq.sv
// ----------------------------------------------------------------------------
// cnt_cmd_seq
// Command sequencer feeding a 16-bit up/down counter. LOAD/UP/DOWN/HOLD
// commands arrive on a valid/ready handshake, are queued in cnt_cmd_fifo and
// expanded into cycle-exact counter controls. Commands run back to back with
// no idle cycle between them while the queue is non-empty.
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   cmd_valid/cmd_ready         command handshake
//   cmd_op, cmd_arg             opcode and load value / cycle count
//   abort                       synchronous flush of queue and current command
//   data_in, ld_cnt, updn_cnt,
//   count_enb                   registered counter controls
//   busy                        executing or commands queued
//   done                        pulse in the final cycle of each command
// ----------------------------------------------------------------------------
module cnt_cmd_seq
   import cnt_seq_pkg::*;
#(
   parameter int DATA_W     = DEF_DATA_W,
   parameter int LEN_W      = DEF_LEN_W,
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_op,
   input  logic [DATA_W-1:0] cmd_arg,
   input  logic              abort,
   output logic [DATA_W-1:0] data_in,
   output logic              ld_cnt,
   output logic              updn_cnt,
   output logic              count_enb,
   output logic              busy,
   output logic              done
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [LEN_W-1:0] REM_ZERO = {LEN_W{1'b0}};
   localparam logic [LEN_W-1:0] REM_ONE  = LEN_W'(1'b1);
   localparam logic [LEN_W-1:0] REM_TWO  = LEN_W'(2'd2);

   state_t           state_r;
   logic [LEN_W-1:0] rem_r;

   cmd_t             wr_cmd_s;
   cmd_t             head_s;
   logic             fifo_full_s;
   logic             fifo_empty_s;
   logic [CW-1:0]    fifo_count_s;
   logic             push_s;
   logic             pop_s;
   logic             last_s;
   logic [LEN_W-1:0] head_n_s;
   logic [LEN_W-1:0] head_len_s;
   logic             head_counts_s;

   // Held in reset, the block advertises no space.
   assign cmd_ready = !rst && !fifo_full_s && !abort;
   assign push_s    = cmd_valid && cmd_ready;
   assign busy      = (state_r == EXEC) || (fifo_count_s != {CW{1'b0}});

   // Final cycle of the running command; the next command may start here.
   assign last_s = (state_r == EXEC) && (rem_r == REM_ONE);
   assign pop_s  = !abort && !fifo_empty_s && ((state_r == IDLE) || last_s);

   // Pack the incoming command for the queue.
   always_comb begin
      wr_cmd_s.op  = op_t'(cmd_op);
      wr_cmd_s.arg = cmd_arg;
   end

   // Decode the head command: its length (LOAD and N=0 take one cycle) and
   // whether it actually makes the counter count.
   always_comb begin
      head_n_s = head_s.arg[LEN_W-1:0];
      if ((head_s.op == LOAD) || (head_n_s == REM_ZERO)) begin
         head_len_s = REM_ONE;
      end else begin
         head_len_s = head_n_s;
      end
      head_counts_s = is_count_op(head_s.op) && (head_n_s != REM_ZERO);
   end

   cnt_cmd_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (push_s),
      .pop     (pop_s),
      .flush   (abort),
      .wr_data (wr_cmd_s),
      .rd_data (head_s),
      .full    (fifo_full_s),
      .empty   (fifo_empty_s),
      .count   (fifo_count_s)
   );

   // Sequencer FSM, remaining-cycle counter and registered counter controls.
   // done is registered one step ahead: it is set when the next cycle will be
   // the last one of the command.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r   <= IDLE;
         rem_r     <= REM_ZERO;
         data_in   <= {DATA_W{1'b0}};
         ld_cnt    <= 1'b0;
         updn_cnt  <= 1'b0;
         count_enb <= 1'b0;
         done      <= 1'b0;
      end else if (abort) begin
         state_r   <= IDLE;
         rem_r     <= REM_ZERO;
         ld_cnt    <= 1'b0;
         count_enb <= 1'b0;
         done      <= 1'b0;
      end else if (pop_s) begin
         state_r   <= EXEC;
         rem_r     <= head_len_s;
         ld_cnt    <= (head_s.op == LOAD);
         count_enb <= head_counts_s;
         done      <= (head_len_s == REM_ONE);
         if (head_s.op == LOAD) begin
            data_in <= head_s.arg;
         end
         if (head_counts_s) begin
            updn_cnt <= (head_s.op == UP);
         end
      end else if (last_s) begin
         state_r   <= IDLE;
         rem_r     <= REM_ZERO;
         ld_cnt    <= 1'b0;
         count_enb <= 1'b0;
         done      <= 1'b0;
      end else if (state_r == EXEC) begin
         rem_r <= rem_r - REM_ONE;
         done  <= (rem_r == REM_TWO);
      end else begin
         ld_cnt    <= 1'b0;
         count_enb <= 1'b0;
         done      <= 1'b0;
      end
   end

endmodule

// File: tb/tb_cnt_cmd_seq.sv
// ----------------------------------------------------------------------------
// tb_cnt_cmd_seq
// Self-checking bench for cnt_cmd_seq. A queue-based reference model tracks
// accepted commands and the cycles left in the running one; every cycle the
// DUT outputs are compared against it. Directed scenarios add literal checks,
// and a downstream counter model is driven from the DUT controls.
// ----------------------------------------------------------------------------
module tb_cnt_cmd_seq;
   import cnt_seq_pkg::*;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_op;
   logic [15:0] cmd_arg;
   logic        abort;
   logic [15:0] data_in;
   logic        ld_cnt;
   logic        updn_cnt;
   logic        count_enb;
   logic        busy;
   logic        done;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   cnt_cmd_seq dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_arg   (cmd_arg),
      .abort     (abort),
      .data_in   (data_in),
      .ld_cnt    (ld_cnt),
      .updn_cnt  (updn_cnt),
      .count_enb (count_enb),
      .busy      (busy),
      .done      (done)
   );

   // Downstream 16-bit up/down counter driven by the DUT controls.
   logic [15:0] cnt_val;
   always @(posedge clk or posedge rst) begin
      if (rst)            cnt_val <= 16'h0000;
      else if (ld_cnt)    cnt_val <= data_in;
      else if (count_enb) cnt_val <= updn_cnt ? cnt_val + 16'd1 : cnt_val - 16'd1;
   end

   // Reference model: accepted commands and the command currently running.
   cmd_t        pend_q[$];
   op_t         cur_op;
   int          cur_n;
   int          cur_left;
   logic [15:0] m_data;
   logic        m_updn;

   // Statistics observed on DUT outputs for the directed scenarios.
   int   done_seen, enb_cycles, up_cycles, enb_rises;
   logic prev_enb;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      pend_q.delete();
      cur_op   = LOAD;
      cur_n    = 0;
      cur_left = 0;
      m_data   = 16'h0000;
      m_updn   = 1'b0;
   endtask

   // Advance the model across one rising edge using the applied inputs.
   task automatic model_edge();
      cmd_t c;
      bit   push;
      if (abort) begin
         pend_q.delete();
         cur_left = 0;
      end else begin
         push = cmd_valid && (pend_q.size() < DEPTH);
         if (cur_left > 0) cur_left--;
         if (cur_left == 0 && pend_q.size() > 0) begin
            c        = pend_q.pop_front();
            cur_op   = c.op;
            cur_n    = int'(c.arg[7:0]);
            cur_left = (cur_op == LOAD || cur_n == 0) ? 1 : cur_n;
            if (cur_op == LOAD) m_data = c.arg;
            if (cur_op == UP   && cur_n != 0) m_updn = 1'b1;
            if (cur_op == DOWN && cur_n != 0) m_updn = 1'b0;
         end
         if (push) begin
            c.op  = op_t'(cmd_op);
            c.arg = cmd_arg;
            pend_q.push_back(c);
         end
      end
   endtask

   task automatic compare_all();
      bit ex;
      ex = (cur_left > 0);
      check("ld_cnt",    ld_cnt,    ex && cur_op == LOAD);
      check("count_enb", count_enb, ex && (cur_op == UP || cur_op == DOWN) && cur_n != 0);
      check("done",      done,      ex && cur_left == 1);
      check("updn_cnt",  updn_cnt,  m_updn);
      check("data_in",   data_in,   m_data);
      check("busy",      busy,      ex || pend_q.size() > 0);
      check("cmd_ready", cmd_ready, !abort && pend_q.size() < DEPTH);
   endtask

   task automatic clear_stats();
      done_seen = 0; enb_cycles = 0; up_cycles = 0; enb_rises = 0; prev_enb = 1'b0;
   endtask

   // One clock: apply inputs, step the model at the edge, compare at negedge.
   task automatic tick(input logic v, input logic [1:0] op, input logic [15:0] arg,
                       input logic ab);
      cmd_valid = v; cmd_op = op; cmd_arg = arg; abort = ab;
      @(posedge clk);
      model_edge();
      @(negedge clk);
      compare_all();
      if (done) done_seen++;
      if (count_enb) begin
         enb_cycles++;
         if (updn_cnt) up_cycles++;
         if (!prev_enb) enb_rises++;
      end
      prev_enb = count_enb;
   endtask

   task automatic drain();
      int guard;
      guard = 0;
      while ((cur_left > 0 || pend_q.size() > 0) && guard < 400) begin
         tick(1'b0, 2'd0, 16'h0000, 1'b0);
         guard++;
      end
      check("drain_timeout", guard, (guard < 400) ? guard : 0);
      tick(1'b0, 2'd0, 16'h0000, 1'b0);
   endtask

   initial begin
      logic [1:0]  ops  [5];
      logic [15:0] args [5];
      int          idx, guard;
      bit          saw_full, acc;
      logic [1:0]  rop;
      logic [15:0] rarg;

      rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_arg = 16'h0000; abort = 1'b0;
      model_reset();
      clear_stats();
      repeat (2) @(negedge clk);
      check("rst_ld_cnt",    ld_cnt,    1'b0);
      check("rst_count_enb", count_enb, 1'b0);
      check("rst_done",      done,      1'b0);
      check("rst_busy",      busy,      1'b0);
      check("rst_data_in",   data_in,   16'h0000);
      check("rst_cmd_ready", cmd_ready, 1'b0);
      rst = 1'b0;
      #1;
      check("post_rst_cmd_ready", cmd_ready, 1'b1);
      compare_all();

      // LOAD A5A5: first control cycle one edge after acceptance.
      tick(1'b1, LOAD, 16'hA5A5, 1'b0);
      check("load_latency_ld", ld_cnt, 1'b0);
      tick(1'b0, 2'd0, 16'h0000, 1'b0);
      check("load_ld",   ld_cnt,  1'b1);
      check("load_data", data_in, 16'hA5A5);
      check("load_done", done,    1'b1);
      tick(1'b0, 2'd0, 16'h0000, 1'b0);
      check("load_idle_busy", busy, 1'b0);

      // LOAD 0x10, UP 5, DOWN 3 back to back.
      clear_stats();
      tick(1'b1, LOAD, 16'h0010, 1'b0);
      tick(1'b1, UP,   16'h0005, 1'b0);
      tick(1'b1, DOWN, 16'h0003, 1'b0);
      drain();
      check("seq_done_pulses", done_seen,  3);
      check("seq_enb_cycles",  enb_cycles, 8);
      check("seq_up_cycles",   up_cycles,  5);
      check("seq_enb_contig",  enb_rises,  1);
      check("seq_counter",     cnt_val,    16'h0012);

      // Five commands with cmd_valid held until each is accepted.
      ops[0] = UP;   args[0] = 16'h0008;
      ops[1] = DOWN; args[1] = 16'h0002;
      ops[2] = HOLD; args[2] = 16'h0003;
      ops[3] = LOAD; args[3] = 16'h1234;
      ops[4] = UP;   args[4] = 16'h0004;
      clear_stats();
      idx = 0; guard = 0; saw_full = 0;
      while (idx < 5 && guard < 100) begin
         acc = (pend_q.size() < DEPTH);
         tick(1'b1, ops[idx], args[idx], 1'b0);
         if (acc) idx++;
         if (!cmd_ready) saw_full = 1;
         guard++;
      end
      check("fill_all_accepted", idx, 5);
      check("fill_ready_dropped", saw_full, 1'b1);
      drain();
      check("fill_done_pulses", done_seen, 5);

      // UP 0 then HOLD 4.
      tick(1'b1, UP,   16'h0000, 1'b0);
      tick(1'b1, HOLD, 16'h0004, 1'b0);
      check("up0_enb",  count_enb, 1'b0);
      check("up0_ld",   ld_cnt,    1'b0);
      check("up0_done", done,      1'b1);
      for (int k = 1; k <= 4; k++) begin
         tick(1'b0, 2'd0, 16'h0000, 1'b0);
         check("hold_enb",  count_enb, 1'b0);
         check("hold_done", done, (k == 4) ? 1'b1 : 1'b0);
      end
      drain();

      // Abort in cycle 3 of UP 10 with two commands queued; push ignored.
      clear_stats();
      tick(1'b1, UP,   16'h000A, 1'b0);
      tick(1'b1, DOWN, 16'h0002, 1'b0);
      tick(1'b1, HOLD, 16'h0003, 1'b0);
      tick(1'b0, 2'd0, 16'h0000, 1'b0);
      check("abort_pre_enb", count_enb, 1'b1);
      tick(1'b1, LOAD, 16'hBEEF, 1'b1);
      check("abort_enb",  count_enb, 1'b0);
      check("abort_busy", busy,      1'b0);
      check("abort_done", done,      1'b0);
      for (int k = 0; k < 3; k++) begin
         tick(1'b0, 2'd0, 16'h0000, 1'b0);
         check("abort_after_busy", busy, 1'b0);
      end
      check("abort_no_done", done_seen, 0);

      // Reset in the middle of DOWN 6.
      tick(1'b1, DOWN, 16'h0006, 1'b0);
      repeat (3) tick(1'b0, 2'd0, 16'h0000, 1'b0);
      check("mid_down_enb", count_enb, 1'b1);
      #2 rst = 1'b1;
      #1;
      check("arst_enb",       count_enb, 1'b0);
      check("arst_ld",        ld_cnt,    1'b0);
      check("arst_done",      done,      1'b0);
      check("arst_busy",      busy,      1'b0);
      check("arst_updn",      updn_cnt,  1'b0);
      check("arst_data",      data_in,   16'h0000);
      model_reset();
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("rel_cmd_ready", cmd_ready, 1'b1);
      check("rel_busy",      busy,      1'b0);
      tick(1'b1, UP, 16'h0002, 1'b0);
      drain();

      // Randomized traffic; upper arg bits of counted ops are noise.
      for (int i = 0; i < 800; i++) begin
         rop = 2'($urandom_range(0, 3));
         if (rop == LOAD) rarg = 16'($urandom);
         else rarg = {8'($urandom), 8'($urandom_range(0, 5))};
         tick(($urandom_range(0, 9) < 6) ? 1'b1 : 1'b0, rop, rarg,
              ($urandom_range(0, 99) < 3) ? 1'b1 : 1'b0);
      end
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/cnt_cmd_seq.md
# cnt_cmd_seq

Command sequencer that sits directly upstream of the 16-bit up/down counter and drives its `data_in`, `ld_cnt`, `updn_cnt` and `count_enb` inputs. It accepts LOAD/UP/DOWN/HOLD commands over a valid/ready handshake and buffers them in a small FIFO. Each command is expanded into a cycle-exact control sequence, so the counter runs without a testbench or CPU toggling its controls every cycle.

## Interface
- `DATA_W`, 16, width of the load value and of `data_in`
- `LEN_W`, 8, width of the run/hold cycle count taken from `cmd_arg[LEN_W-1:0]`
- `FIFO_DEPTH`, 4, command FIFO entries (power of two, ≥2)
- `clk`  in  1  single clock; all state updates on posedge
- `rst`  in  1  reset, asynchronous, active-high
- `cmd_valid`  in  1  command present
- `cmd_ready`  out  1  FIFO can accept a command
- `cmd_op`  in  2  0=LOAD, 1=UP, 2=DOWN, 3=HOLD
- `cmd_arg`  in  DATA_W  load value (LOAD) or cycle count N in low LEN_W bits (UP/DOWN/HOLD)
- `abort`  in  1  synchronous flush of FIFO and current command
- `data_in`  out  DATA_W  counter load value
- `ld_cnt`  out  1  counter load strobe
- `updn_cnt`  out  1  counter direction, 1=up
- `count_enb`  out  1  counter enable
- `busy`  out  1  command executing or FIFO non-empty
- `done`  out  1  one-cycle pulse in the final cycle of each command

## Operation
- Push on `cmd_valid && cmd_ready`. `cmd_ready = !full && !abort`. A push while full is impossible by construction.
- FSM states: IDLE, EXEC.
  - IDLE: if the FIFO is non-empty, pop, register op/arg, load the down-counter `rem = N` (or 1 for LOAD), go to EXEC.
  - EXEC: decrement `rem` each cycle. In the cycle where `rem == 1`, `done=1`. If the FIFO is non-empty, pop the next command on the same edge (no bubble); otherwise go to IDLE.
- Per-op output values during EXEC:
  - LOAD: 1 cycle, `ld_cnt=1`, `data_in=arg`, `count_enb=0`.
  - UP: N cycles, `count_enb=1`, `updn_cnt=1`.
  - DOWN: N cycles, `count_enb=1`, `updn_cnt=0`.
  - HOLD: N cycles, `count_enb=0`, `ld_cnt=0`.
- N=0 for UP/DOWN/HOLD: 1 cycle, all strobes low, `done=1`.
- `data_in` holds its last loaded value outside LOAD. `updn_cnt` holds its last direction outside UP/DOWN.
- In IDLE: `ld_cnt=0`, `count_enb=0`, `done=0`.
- `busy = (state==EXEC) || !empty`.
- `abort`: at the next edge, FIFO emptied, state→IDLE, `ld_cnt`/`count_enb` low, no `done` for the aborted command. Abort has priority over push and pop in the same cycle.
- The counter's active-low reset is tied to `!rst` at the top level; this block does not drive it.

## Timing
- All outputs registered.
- Reset value of every output is 0; `cmd_ready=1` after reset release.
- Latency: a command accepted at edge E0 with the sequencer idle and FIFO empty drives its first control cycle after edge E1.
- Back-to-back commands produce contiguous control cycles; total cycles = sum of per-command lengths.
- FIFO is full with FIFO_DEPTH entries held. A pop and a push in the same cycle are both honoured.
- Reset mid-command: outputs and FIFO clear immediately (async). No partial command resumes.

## Structure
- Package `cnt_seq_pkg`:
  - `op_t` enum (LOAD, UP, DOWN, HOLD)
  - `state_t` enum (IDLE, EXEC)
  - default DATA_W/LEN_W localparams
  - packed `cmd_t {op_t op; logic [DATA_W-1:0] arg;}`
- Sub-module `cnt_cmd_fifo`: synchronous FIFO of `cmd_t` with push/pop/flush, full/empty and an occupancy count.
- Top level holds the FSM, the `rem` counter and the output registers.

## Test plan
- Reset, push LOAD 16'hA5A5 → one cycle later `ld_cnt=1`, `data_in=16'hA5A5`, `done=1` in the same cycle, then IDLE with `busy=0`.
- Push LOAD 16'h0010, UP 5, DOWN 3 back-to-back → `ld_cnt` 1 cycle, `count_enb` high for 8 contiguous cycles (`updn_cnt` 1×5 then 0×3), exactly three `done` pulses; counter `data_out` ends at 16'h0012.
- Push 5 commands without idling, holding `cmd_valid` → `cmd_ready` drops after the FIFO fills; all 5 commands eventually execute in order, none lost.
- UP 0 and HOLD 4 → UP 0 gives 1 cycle with strobes low and `done`; HOLD 4 gives `count_enb=0` for 4 cycles with `done` on the 4th.
- `abort` during cycle 3 of UP 10 with 2 queued → `count_enb` low next cycle, FIFO empty, `busy=0`, no `done`; a push in the abort cycle is ignored.
- Assert `rst` mid-DOWN 6 → all outputs 0 immediately; after release the block is idle and accepts new commands with `cmd_ready=1`.
